// File: rtl/filter_weight_fetch.sv
// Read-side sequencer for the filter weight memory: walks ROWS x COLS row-major, packs the weights.
// Optional build macro WFETCH_SUM_EN adds a signed running sum of the fetched weights on w_sum.
module filter_weight_fetch #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned SUM_W  = DATA_W + 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  output logic                          busy,
  output logic [ADDR_W-1:0]             mem_addr1,
  output logic [ADDR_W-1:0]             mem_addr2,
  output logic                          mem_sel,
  output logic                          mem_wr,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          w_valid,
  input  logic                          w_ready,
  output logic [ROWS*COLS*DATA_W-1:0]   w_data,
  output logic [SUM_W-1:0]              w_sum
);

  localparam int unsigned NUM_W = ROWS * COLS;
  localparam int unsigned IDX_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_row;
  logic [ADDR_W-1:0]   r_col;
  logic                r_sel;
  logic                r_valid;
  logic                r_busy;
  logic [DATA_W-1:0]   r_slot [NUM_W];

  logic [IDX_W-1:0]    w_idx;
  logic                w_last;
  logic                w_col_wrap;

  // Row/column counters double as the memory address; they stay at 0 outside FETCH.
  assign w_idx      = IDX_W'(32'(r_row) * 32'(COLS) + 32'(r_col));
  assign w_col_wrap = (r_col == ADDR_W'(COLS - 1));
  assign w_last     = (r_row == ADDR_W'(ROWS - 1)) && w_col_wrap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      for (int k = 0; k < NUM_W; k++) r_slot[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_sel   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_slot[w_idx] <= mem_rdata;
          if (w_last) begin
            r_state <= S_HOLD;
            r_sel   <= 1'b0;
            r_valid <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
          end else if (w_col_wrap) begin
            r_col <= '0;
            r_row <= r_row + ADDR_W'(1);
          end else begin
            r_col <= r_col + ADDR_W'(1);
          end
        end
        S_HOLD: begin
          // A start in the acceptance cycle chains straight into the next fetch.
          if (w_ready) begin
            r_valid <= 1'b0;
            if (start) begin
              r_state <= S_FETCH;
              r_sel   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_row   <= '0;
          r_col   <= '0;
          r_sel   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign mem_addr1 = r_row;
  assign mem_addr2 = r_col;
  assign mem_sel   = r_sel;
  assign mem_wr    = 1'b0;
  assign w_valid   = r_valid;

  for (genvar k = 0; k < NUM_W; k++) begin : g_pack
    assign w_data[k*DATA_W +: DATA_W] = r_slot[k];
  end

`ifdef WFETCH_SUM_EN
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_ext;

  assign w_ext = {{(SUM_W - DATA_W){mem_rdata[DATA_W-1]}}, mem_rdata};

  // The first element of a fetch restarts the accumulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum <= '0;
    end else if (r_state == S_FETCH) begin
      r_sum <= (w_idx == '0) ? w_ext : r_sum + w_ext;
    end
  end

  assign w_sum = r_sum;
`else
  assign w_sum = '0;
`endif

endmodule

// File: tb/tb_filter_weight_fetch.sv
// Directed bench for filter_weight_fetch with a combinational 3x3 weight memory model.
module tb_filter_weight_fetch;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        busy;
  logic [4:0]  mem_addr1;
  logic [4:0]  mem_addr2;
  logic        mem_sel;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [71:0] w_data;
  logic [11:0] w_sum;

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int lat;

  logic [7:0]  mem   [9];
  logic [7:0]  set_a [9] = '{8'h81, 8'hF9, 8'hC0, 8'hAE, 8'h22, 8'hC4, 8'hD5, 8'h40, 8'h30};
  logic [7:0]  set_b [9] = '{8'h01, 8'hFE, 8'h03, 8'hFC, 8'h05, 8'hFA, 8'h07, 8'hF8, 8'h09};
  logic [71:0] exp_data;
  logic [11:0] exp_sum;

  filter_weight_fetch dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .busy      (busy),
    .mem_addr1 (mem_addr1),
    .mem_addr2 (mem_addr2),
    .mem_sel   (mem_sel),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_sum     (w_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = '0;
    if (mem_sel && (mem_addr1 < 5'd3) && (mem_addr2 < 5'd3))
      mem_rdata = mem[int'(mem_addr1) * 3 + int'(mem_addr2)];
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge, check mem_wr and the read address sequence.
  task automatic tick();
    @(posedge clk);
    #1;
    check("mem_wr", 96'(mem_wr), 96'(0));
    if (mem_sel === 1'b1) begin
      check("addr1", 96'(mem_addr1), 96'((rd_cnt % 9) / 3));
      check("addr2", 96'(mem_addr2), 96'(rd_cnt % 3));
      rd_cnt++;
    end
  endtask

  task automatic load(input bit use_b);
    for (int k = 0; k < 9; k++) begin
      mem[k] = use_b ? set_b[k] : set_a[k];
      exp_data[k*8 +: 8] = mem[k];
    end
`ifdef WFETCH_SUM_EN
    exp_sum = use_b ? 12'd5 : 12'hF13;
`else
    exp_sum = 12'd0;
`endif
  endtask

  task automatic wait_valid(output int l);
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (w_valid === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  96'(busy),      96'(0));
    check({tag, "_sel"},   96'(mem_sel),   96'(0));
    check({tag, "_addr1"}, 96'(mem_addr1), 96'(0));
    check({tag, "_addr2"}, 96'(mem_addr2), 96'(0));
    check({tag, "_valid"}, 96'(w_valid),   96'(0));
    check({tag, "_data"},  96'(w_data),    96'(0));
    check({tag, "_sum"},   96'(w_sum),     96'(0));
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 1'b0;
    w_ready = 1'b0;
    load(1'b0);
    tick();
    check_reset_outputs("reset");
    tick();
    rstn = 1'b1;
    tick();
    check_reset_outputs("idle");

    // 1: basic fetch, consumer ready
    rd_cnt = 0;
    w_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", 96'(busy), 96'(1));
    check("t1_sel_first", 96'(mem_sel), 96'(1));
    wait_valid(lat);
    check("t1_latency", 96'(lat), 96'(9));
    check("t1_reads", 96'(rd_cnt), 96'(9));
    check("t1_data", 96'(w_data), 96'(exp_data));
    check("t1_sum", 96'(w_sum), 96'(exp_sum));
    check("t1_sel_hold", 96'(mem_sel), 96'(0));
    tick();
    check("t1_valid_after", 96'(w_valid), 96'(0));
    check("t1_busy_after", 96'(busy), 96'(0));

    // 2: consumer stalls for five cycles, a stray start in HOLD is ignored
    rd_cnt = 0;
    w_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("t2_latency", 96'(lat), 96'(9));
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check("t2_valid_hold", 96'(w_valid), 96'(1));
      check("t2_data_hold", 96'(w_data), 96'(exp_data));
      check("t2_busy_hold", 96'(busy), 96'(1));
    end
    start = 1'b0;
    w_ready = 1'b1;
    tick();
    check("t2_valid_acc", 96'(w_valid), 96'(0));
    check("t2_busy_acc", 96'(busy), 96'(0));
    tick();
    check("t2_no_refetch", 96'(mem_sel), 96'(0));

    // 3: start pulsed repeatedly during FETCH
    rd_cnt = 0;
    start = 1'b1;
    tick();
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (w_valid === 1'b1) begin
        lat = i;
        break;
      end
      start = (i % 2 == 1);
    end
    start = 1'b0;
    check("t3_latency", 96'(lat), 96'(9));
    check("t3_data", 96'(w_data), 96'(exp_data));
    tick();
    check("t3_valid_after", 96'(w_valid), 96'(0));
    tick();
    check("t3_busy_idle", 96'(busy), 96'(0));
    check("t3_reads", 96'(rd_cnt), 96'(9));

    // 4: start in the acceptance cycle chains into a fetch of new weights
    rd_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("t4a_latency", 96'(lat), 96'(9));
    check("t4a_data", 96'(w_data), 96'(exp_data));
    start = 1'b1;
    load(1'b1);
    rd_cnt = 0;
    tick();
    start = 1'b0;
    check("t4_sel_b2b", 96'(mem_sel), 96'(1));
    check("t4_addr_b2b", 96'({mem_addr1, mem_addr2}), 96'(0));
    check("t4_valid_b2b", 96'(w_valid), 96'(0));
    check("t4_busy_b2b", 96'(busy), 96'(1));
    wait_valid(lat);
    check("t4b_latency", 96'(lat), 96'(9));
    check("t4b_reads", 96'(rd_cnt), 96'(9));
    check("t4b_data", 96'(w_data), 96'(exp_data));
    check("t4b_sum", 96'(w_sum), 96'(exp_sum));
    tick();
    check("t4_valid_after", 96'(w_valid), 96'(0));

    // 5: reset during the 4th FETCH cycle, then a clean refetch
    load(1'b0);
    rd_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("t5_in_fetch", 96'(mem_sel), 96'(1));
    rstn = 1'b0;
    #1;
    check_reset_outputs("t5_abort");
    tick();
    check_reset_outputs("t5_held");
    rstn = 1'b1;
    tick();
    check("t5_no_valid", 96'(w_valid), 96'(0));
    rd_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_addr", 96'({mem_sel, mem_addr1, mem_addr2}), 96'({1'b1, 10'd0}));
    wait_valid(lat);
    check("t5_latency", 96'(lat), 96'(9));
    check("t5_reads", 96'(rd_cnt), 96'(9));
    check("t5_data", 96'(w_data), 96'(exp_data));
    check("t5_sum", 96'(w_sum), 96'(exp_sum));
    tick();
    check("t5_valid_after", 96'(w_valid), 96'(0));
    check("t5_busy_after", 96'(busy), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
